// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Arbitrates exception > taken branch > load-use requests, then drives the
// PC-mux controls (PcWrite/pc_src/pc_flush/if_lw/error) and the redirect address.
// Controls are combinational from the registered state and the current inputs,
// so a redirect appears in the same cycle as its request and the new PC is
// loaded at the next clock edge.
// Optional build macro FETCH_PERF_EN adds wrapping performance counters
// (stall_cnt, flush_cnt, exc_cnt).
module fetch_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned LU_STALL   = 1,
  parameter int unsigned FLUSH_CYC  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        load_use,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  output logic        PcWrite,
  output logic        pc_src,
  output logic        pc_flush,
  output logic        if_lw,
  output logic        error,
  output logic [31:0] address,
  output logic [31:0] error_address,
`ifdef FETCH_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] exc_cnt,
`endif
  output logic [31:0] epc,
  output logic        exc_ack
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    TRAP  = 2'd3
  } state_t;

  // Reload values for the down-counter; a value of 1 means the hold state
  // lasts one extra cycle beyond the request cycle.
  localparam logic [7:0] LU_RELOAD    = 8'(LU_STALL - 1);
  localparam logic [7:0] FLUSH_RELOAD = 8'(FLUSH_CYC - 1);
  localparam state_t     LU_NEXT      = (LU_STALL > 1)  ? STALL : RUN;
  localparam state_t     BR_NEXT      = (FLUSH_CYC > 1) ? FLUSH : RUN;
  localparam state_t     EXC_NEXT     = (FLUSH_CYC > 1) ? TRAP  : RUN;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;

  // Request decode per state: which request (if any) is accepted this cycle.
  logic take_exc, take_br, take_lu;

  // Accept requests according to the current state's masking rules.
  always_comb begin
    take_exc = 1'b0;
    take_br  = 1'b0;
    take_lu  = 1'b0;
    case (state_q)
      RUN: begin
        if (exc_req)           take_exc = 1'b1;
        else if (branch_taken) take_br  = 1'b1;
        else if (load_use)     take_lu  = 1'b1;
      end
      STALL: begin
        // Only an exception can break a load-use stall.
        if (exc_req) take_exc = 1'b1;
      end
      FLUSH: begin
        // A younger taken branch restarts the redirect; load-use is moot
        // because the decode slot is being squashed.
        if (exc_req)           take_exc = 1'b1;
        else if (branch_taken) take_br  = 1'b1;
      end
      default: begin
        // TRAP: everything masked so the handler entry is never nested.
      end
    endcase
  end

  // Next-state, counter, epc and fetch controls.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    PcWrite  = 1'b1;
    pc_src   = 1'b0;
    pc_flush = 1'b0;
    if_lw    = 1'b0;
    error    = 1'b0;
    exc_ack  = 1'b0;
    address  = 32'h0;

    if (take_exc) begin
      error    = 1'b1;
      pc_src   = 1'b1;
      pc_flush = 1'b1;
      exc_ack  = 1'b1;
      address  = EXC_VECTOR;
      epc_d    = exc_pc;
      cnt_d    = FLUSH_RELOAD;
      state_d  = EXC_NEXT;
    end else if (take_br) begin
      pc_src   = 1'b1;
      pc_flush = 1'b1;
      address  = branch_target;
      cnt_d    = FLUSH_RELOAD;
      state_d  = BR_NEXT;
    end else if (take_lu) begin
      PcWrite  = 1'b0;
      if_lw    = 1'b1;
      cnt_d    = LU_RELOAD;
      state_d  = LU_NEXT;
    end else begin
      case (state_q)
        STALL: begin
          PcWrite = 1'b0;
          if_lw   = 1'b1;
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_d = RUN;
        end
        FLUSH, TRAP: begin
          pc_flush = 1'b1;
          cnt_d    = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_d = RUN;
        end
        default: begin
          // RUN with no request: sequential fetch.
        end
      endcase
    end

    // While reset is held the fetch stage just free-runs; state is
    // cleared at the clock edge.
    if (reset) begin
      PcWrite  = 1'b1;
      pc_src   = 1'b0;
      pc_flush = 1'b0;
      if_lw    = 1'b0;
      error    = 1'b0;
      exc_ack  = 1'b0;
      address  = 32'h0;
    end
  end

  assign epc           = reset ? 32'h0 : epc_q;
  assign error_address = EXC_VECTOR;

  // State, counter and exception-PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, exc_cnt_q;

  // Event counters: one count per cycle the corresponding control is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
      exc_cnt_q   <= 32'h0;
    end else begin
      if (if_lw)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pc_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (exc_ack)  exc_cnt_q   <= exc_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign exc_cnt   = exc_cnt_q;
`endif

endmodule
